// File: rtl/i2c_temp_target.sv
// ---------------------------------------------------------------------------
// i2c_temp_target
// I2C target that stands in for the board temperature sensor. It detects
// START/STOP on synchronized SCL/SDA, matches a 7-bit address and serves a
// small register map (temperature MSB/LSB, config, ID) through an 8-bit
// auto-incrementing pointer. SDA is only ever pulled low (open drain).
//
// Ports
//   clk_i        system clock, at least 16x the SCL rate
//   rst_i        asynchronous active-high reset
//   scl_i        bus SCL level (never stretched by this target)
//   sda_i        bus SDA level
//   sda_oe_o     1 pulls SDA low, 0 releases it
//   temp_i       temperature sample, MSB:LSB
//   temp_upd_i   one-cycle strobe to load temp_i into the shadow register
//   cfg_o        config register contents
//   busy_o       high from an address-matched START until the next STOP
//   wr_strobe_o  one-cycle pulse after each data byte written
//   rd_done_o    one-cycle pulse when the initiator NACKs a read byte
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_temp_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h4B,
   parameter logic [7:0] ID_VALUE    = 8'hCB,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe_o,
   input  logic [15:0] temp_i,
   input  logic        temp_upd_i,
   output logic [7:0]  cfg_o,
   output logic        busy_o,
   output logic        wr_strobe_o,
   output logic        rd_done_o
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_PTR       = 4'd3;
   localparam logic [3:0] S_PTR_ACK   = 4'd4;
   localparam logic [3:0] S_WDATA     = 4'd5;
   localparam logic [3:0] S_WDATA_ACK = 4'd6;
   localparam logic [3:0] S_RDATA     = 4'd7;
   localparam logic [3:0] S_RDATA_ACK = 4'd8;
   localparam logic [3:0] S_WAIT      = 4'd9;

   logic [SYNC_STAGES-1:0] r_sclSync;
   logic [SYNC_STAGES-1:0] r_sdaSync;
   logic                   r_sclPrev;
   logic                   r_sdaPrev;

   logic [3:0]  r_state;
   logic [3:0]  r_bitCnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_ptr;
   logic [7:0]  r_cfg;
   logic [15:0] r_shadow;
   logic        r_pend;
   logic [15:0] r_pendVal;
   logic        r_oe;
   logic        r_busy;
   logic        r_wrStb;
   logic        r_rdDone;
   logic        r_rw;
   logic        r_mAck;

   logic        w_scl;
   logic        w_sda;
   logic        w_sclRise;
   logic        w_sclFall;
   logic        w_start;
   logic        w_stop;
   logic [7:0]  w_rdByte;

   // Synchronizers reset to 1 so an idle (pulled-up) bus does not look like
   // an edge when reset is released. One extra stage holds the previous
   // synchronized level for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sclSync <= '1;
         r_sdaSync <= '1;
         r_sclPrev <= 1'b1;
         r_sdaPrev <= 1'b1;
      end else begin
         r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl_i};
         r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda_i};
         r_sclPrev <= r_sclSync[SYNC_STAGES-1];
         r_sdaPrev <= r_sdaSync[SYNC_STAGES-1];
      end
   end

   assign w_scl     = r_sclSync[SYNC_STAGES-1];
   assign w_sda     = r_sdaSync[SYNC_STAGES-1];
   assign w_sclRise = w_scl & ~r_sclPrev;
   assign w_sclFall = ~w_scl & r_sclPrev;
   // START/STOP require SCL high on both samples so an SDA change that
   // coincides with an SCL edge is treated as data, not a bus condition.
   assign w_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
   assign w_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;

   // Register map read mux; unmapped addresses read as zero.
   always_comb begin
      w_rdByte = 8'h00;
      case (r_ptr)
         8'h00:   w_rdByte = r_shadow[15:8];
         8'h01:   w_rdByte = r_shadow[7:0];
         8'h03:   w_rdByte = r_cfg;
         8'h0B:   w_rdByte = ID_VALUE;
         default: w_rdByte = 8'h00;
      endcase
   end

   // Protocol state machine. Bits are shifted in on SCL rise; SDA drive is
   // only ever changed on SCL fall so it is stable for the whole high time.
   // The pointer persists across STOP so a bare read resumes where the last
   // transfer left off.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_bitCnt <= 4'd0;
         r_shift  <= 8'h00;
         r_ptr    <= 8'h00;
         r_cfg    <= 8'h00;
         r_oe     <= 1'b0;
         r_busy   <= 1'b0;
         r_wrStb  <= 1'b0;
         r_rdDone <= 1'b0;
         r_rw     <= 1'b0;
         r_mAck   <= 1'b0;
      end else begin
         r_wrStb  <= 1'b0;
         r_rdDone <= 1'b0;
         if (w_start) begin
            r_state  <= S_ADDR;
            r_bitCnt <= 4'd0;
            r_oe     <= 1'b0;
         end else if (w_stop) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR, S_PTR, S_WDATA: begin
                  if (w_sclRise && r_bitCnt < 4'd8) begin
                     r_shift  <= {r_shift[6:0], w_sda};
                     r_bitCnt <= r_bitCnt + 4'd1;
                  end else if (w_sclFall && r_bitCnt == 4'd8) begin
                     if (r_state == S_ADDR) begin
                        if (r_shift[7:1] == DEV_ADDR) begin
                           r_state <= S_ADDR_ACK;
                           r_oe    <= 1'b1;
                           r_busy  <= 1'b1;
                           r_rw    <= r_shift[0];
                        end else begin
                           r_state <= S_IDLE;
                           r_oe    <= 1'b0;
                        end
                     end else if (r_state == S_PTR) begin
                        r_state <= S_PTR_ACK;
                        r_oe    <= 1'b1;
                     end else begin
                        r_state <= S_WDATA_ACK;
                        r_oe    <= 1'b1;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (w_sclFall) begin
                     r_bitCnt <= 4'd0;
                     if (r_rw) begin
                        r_state <= S_RDATA;
                        r_shift <= w_rdByte;
                        r_oe    <= ~w_rdByte[7];
                     end else begin
                        r_state <= S_PTR;
                        r_oe    <= 1'b0;
                     end
                  end
               end
               S_PTR_ACK: begin
                  if (w_sclRise) begin
                     r_ptr <= r_shift;
                  end else if (w_sclFall) begin
                     r_state  <= S_WDATA;
                     r_bitCnt <= 4'd0;
                     r_oe     <= 1'b0;
                  end
               end
               S_WDATA_ACK: begin
                  // Writes to read-only or unmapped addresses are dropped,
                  // but still strobe and advance the pointer.
                  if (w_sclRise) begin
                     if (r_ptr == 8'h03) begin
                        r_cfg <= r_shift;
                     end
                     r_wrStb <= 1'b1;
                     r_ptr   <= r_ptr + 8'd1;
                  end else if (w_sclFall) begin
                     r_state  <= S_WDATA;
                     r_bitCnt <= 4'd0;
                     r_oe     <= 1'b0;
                  end
               end
               S_RDATA: begin
                  // Bit 7 was driven on entry; falls 1..7 drive bits 6..0
                  // and the fall after bit 0 hands SDA to the initiator.
                  if (w_sclRise && r_bitCnt < 4'd8) begin
                     r_bitCnt <= r_bitCnt + 4'd1;
                  end else if (w_sclFall) begin
                     if (r_bitCnt == 4'd8) begin
                        r_state <= S_RDATA_ACK;
                        r_oe    <= 1'b0;
                     end else begin
                        r_oe <= ~r_shift[3'd7 - r_bitCnt[2:0]];
                     end
                  end
               end
               S_RDATA_ACK: begin
                  if (w_sclRise) begin
                     if (!w_sda) begin
                        r_mAck <= 1'b1;
                        r_ptr  <= r_ptr + 8'd1;
                     end else begin
                        r_mAck   <= 1'b0;
                        r_rdDone <= 1'b1;
                     end
                  end else if (w_sclFall) begin
                     if (r_mAck) begin
                        r_state  <= S_RDATA;
                        r_bitCnt <= 4'd0;
                        r_shift  <= w_rdByte;
                        r_oe     <= ~w_rdByte[7];
                     end else begin
                        r_state <= S_WAIT;
                        r_oe    <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   // Temperature shadow: updates only between transactions so a multi-byte
   // read always sees one coherent sample. A strobe during a transaction is
   // parked (latest value wins) and applied once busy drops after STOP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shadow  <= 16'h0000;
         r_pend    <= 1'b0;
         r_pendVal <= 16'h0000;
      end else if (temp_upd_i) begin
         if (!r_busy) begin
            r_shadow <= temp_i;
            r_pend   <= 1'b0;
         end else begin
            r_pend    <= 1'b1;
            r_pendVal <= temp_i;
         end
      end else if (r_pend && !r_busy) begin
         r_shadow <= r_pendVal;
         r_pend   <= 1'b0;
      end
   end

   assign sda_oe_o    = r_oe;
   assign cfg_o       = r_cfg;
   assign busy_o      = r_busy;
   assign wr_strobe_o = r_wrStb;
   assign rd_done_o   = r_rdDone;

endmodule

// File: tb/tb_i2c_temp_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_temp_target
// Directed bench: an I2C initiator model drives SCL/SDA (wired-AND with the
// target's open-drain output), expected read bytes go into a scoreboard queue
// when a read is set up and are popped as bytes come back off the bus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_temp_target;

   localparam int Q = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclLine = 1'b1;
   logic        sdaMaster = 1'b1;
   logic [15:0] tempIn = 16'h0000;
   logic        tempUpd = 1'b0;
   logic        sdaOe;
   logic [7:0]  cfgOut;
   logic        busyOut;
   logic        wrStb;
   logic        rdDone;
   wire         sdaBus = sdaMaster & ~sdaOe;

   int checks = 0;
   int failures = 0;
   int wrCount = 0;
   int rdCount = 0;
   int busyCycles = 0;
   logic [7:0] expQ[$];

   i2c_temp_target #(.DEV_ADDR(7'h4B), .ID_VALUE(8'hCB), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst), .scl_i(sclLine), .sda_i(sdaBus),
      .sda_oe_o(sdaOe), .temp_i(tempIn), .temp_upd_i(tempUpd),
      .cfg_o(cfgOut), .busy_o(busyOut), .wr_strobe_o(wrStb), .rd_done_o(rdDone)
   );

   // 100 MHz system clock; SCL runs at 2.5 MHz so the ratio is 40x.
   always #5 clk = ~clk;

   // Pulse and busy monitors for the one-cycle outputs.
   always @(posedge clk) begin
      if (wrStb) wrCount++;
      if (rdDone) rdCount++;
      if (busyOut) busyCycles++;
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] t);
      @(negedge clk);
      tempIn = t;
      tempUpd = 1'b1;
      @(negedge clk);
      tempUpd = 1'b0;
   endtask

   task automatic busStart();
      sdaMaster = 1'b1; #Q;
      sclLine = 1'b1;   #Q;
      sdaMaster = 1'b0; #Q;
      sclLine = 1'b0;   #Q;
   endtask

   task automatic busStop();
      sdaMaster = 1'b0; #Q;
      sclLine = 1'b1;   #Q;
      sdaMaster = 1'b1; #Q;
   endtask

   task automatic writeBit(input logic b);
      sdaMaster = b;  #Q;
      sclLine = 1'b1; #(2*Q);
      sclLine = 1'b0; #Q;
   endtask

   task automatic readBit(output logic b);
      sdaMaster = 1'b1; #Q;
      sclLine = 1'b1;   #Q;
      b = sdaBus;       #Q;
      sclLine = 1'b0;   #Q;
   endtask

   task automatic writeByte(input logic [7:0] d, output logic ack);
      logic bit9;
      for (int i = 7; i >= 0; i--) writeBit(d[i]);
      readBit(bit9);
      ack = ~bit9;
   endtask

   task automatic readByte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         readBit(b);
         d[i] = b;
      end
      writeBit(nack);
   endtask

   task automatic checkRead(input string tag, input logic [7:0] got);
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s observed=%h expected=<empty scoreboard>", tag, got);
      end else begin
         checkOutput(tag, {8'h00, got}, {8'h00, expQ.pop_front()});
      end
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         wr0, rd0, busy0;

      // Reset state
      #23;
      checkOutput("rst_oe", {15'd0, sdaOe}, 16'd0);
      checkOutput("rst_busy", {15'd0, busyOut}, 16'd0);
      checkOutput("rst_cfg", {8'd0, cfgOut}, 16'h0000);
      checkOutput("rst_wr", {15'd0, wrStb}, 16'd0);
      checkOutput("rst_rd", {15'd0, rdDone}, 16'd0);
      rst = 1'b0;
      #(2*Q);

      // Pointer write then repeated-START read of temperature
      applyStimulus(16'h1A80);
      wr0 = wrCount; rd0 = rdCount;
      busStart();
      writeByte(8'h96, ack); checkOutput("t1_addr_ack", {15'd0, ack}, 16'd1);
      checkOutput("t1_busy", {15'd0, busyOut}, 16'd1);
      writeByte(8'h00, ack); checkOutput("t1_ptr_ack", {15'd0, ack}, 16'd1);
      busStart();
      writeByte(8'h97, ack); checkOutput("t1_raddr_ack", {15'd0, ack}, 16'd1);
      expQ.push_back(8'h1A); expQ.push_back(8'h80);
      readByte(d, 1'b0); checkRead("t1_msb", d);
      readByte(d, 1'b1); checkRead("t1_lsb", d);
      busStop();
      #Q;
      checkOutput("t1_rd_done", 16'(rdCount - rd0), 16'd1);
      checkOutput("t1_no_wr", 16'(wrCount - wr0), 16'd0);
      checkOutput("t1_busy_off", {15'd0, busyOut}, 16'd0);

      // Config write, then ID read at pointer 0x0B
      wr0 = wrCount;
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'h03, ack);
      writeByte(8'hA5, ack); checkOutput("t2_data_ack", {15'd0, ack}, 16'd1);
      busStop();
      #Q;
      checkOutput("t2_cfg", {8'd0, cfgOut}, 16'h00A5);
      checkOutput("t2_wr", 16'(wrCount - wr0), 16'd1);
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'h0B, ack);
      busStart();
      writeByte(8'h97, ack);
      expQ.push_back(8'hCB);
      readByte(d, 1'b1); checkRead("t2_id", d);
      busStop();
      #Q;

      // Address mismatch
      busy0 = busyCycles; wr0 = wrCount;
      busStart();
      writeByte(8'h90, ack); checkOutput("t3_nack", {15'd0, ack}, 16'd0);
      busStop();
      #Q;
      checkOutput("t3_busy", 16'(busyCycles - busy0), 16'd0);
      checkOutput("t3_cfg", {8'd0, cfgOut}, 16'h00A5);
      checkOutput("t3_wr", 16'(wrCount - wr0), 16'd0);

      // Coherent snapshot across a mid-transfer temperature update
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'h00, ack);
      busStart();
      writeByte(8'h97, ack);
      expQ.push_back(8'h1A); expQ.push_back(8'h80);
      readByte(d, 1'b0); checkRead("t4_old_msb", d);
      applyStimulus(16'h1234);
      readByte(d, 1'b1); checkRead("t4_old_lsb", d);
      busStop();
      #Q;
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'h00, ack);
      busStart();
      writeByte(8'h97, ack);
      expQ.push_back(8'h12); expQ.push_back(8'h34);
      readByte(d, 1'b0); checkRead("t4_new_msb", d);
      readByte(d, 1'b1); checkRead("t4_new_lsb", d);
      busStop();
      #Q;

      // Pointer wrap from 0xFF
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'hFF, ack);
      busStart();
      writeByte(8'h97, ack);
      expQ.push_back(8'h00); expQ.push_back(8'h12);
      readByte(d, 1'b0); checkRead("t5_unmapped", d);
      readByte(d, 1'b1); checkRead("t5_wrapped", d);
      busStop();
      #Q;

      // START after four address bits restarts cleanly
      busStart();
      writeBit(1'b1); writeBit(1'b0); writeBit(1'b0); writeBit(1'b1);
      busStart();
      writeByte(8'h96, ack); checkOutput("t6_restart_ack", {15'd0, ack}, 16'd1);
      writeByte(8'h00, ack);
      busStop();
      #Q;

      // Reset while driving a read bit (0x12 starts with a 0 bit)
      busStart();
      writeByte(8'h97, ack);
      checkOutput("t7_driving", {15'd0, sdaOe}, 16'd1);
      rst = 1'b1;
      #1;
      checkOutput("t7_oe_rst", {15'd0, sdaOe}, 16'd0);
      checkOutput("t7_cfg_rst", {8'd0, cfgOut}, 16'h0000);
      #20;
      rst = 1'b0;
      sdaMaster = 1'b1;
      sclLine = 1'b1;
      #(2*Q);
      checkOutput("t7_busy", {15'd0, busyOut}, 16'd0);

      // After reset the pointer and shadow are both zero
      busStart();
      writeByte(8'h97, ack); checkOutput("t8_ack", {15'd0, ack}, 16'd1);
      expQ.push_back(8'h00);
      readByte(d, 1'b1); checkRead("t8_shadow", d);
      busStop();
      #Q;
      checkOutput("t8_queue_empty", 16'(expQ.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_temp_target.md
# i2c_temp_target

I2C target (responder) that emulates the on-board temperature sensor seen by the `TempSensor` I2C initiator. It decodes START/STOP, matches a 7-bit address and serves a small register map (temperature, config, ID) with pointer auto-increment. It drives SDA open-drain only. It sits in the simulation bench and the loopback build on the far end of the SCL/SDA pins, so the initiator can be exercised without the physical sensor.

## Interface

Parameters:

- `DEV_ADDR`, 7'h4B: 7-bit target address.
- `ID_VALUE`, 8'hCB: value returned by the ID register.
- `SYNC_STAGES`, 2: flip-flop stages on the `scl_i`/`sda_i` synchronizers (≥2).

Ports:

- `clk_i` in 1: system clock. Must be ≥ 16× the SCL frequency.
- `rst_i` in 1: reset, asynchronous, active-high. Clock is `clk_i`.
- `scl_i` in 1: bus SCL level (target never stretches).
- `sda_i` in 1: bus SDA level.
- `sda_oe_o` out 1: 1 pulls SDA low, 0 releases it. The top level builds the tristate.
- `temp_i` in 16: temperature sample from the model/host as MSB:LSB.
- `temp_upd_i` in 1: 1-cycle strobe requesting that `temp_i` be loaded into the shadow register.
- `cfg_o` out 8: current contents of the config register.
- `busy_o` out 1: high from an address-matched START until the next STOP.
- `wr_strobe_o` out 1: 1-cycle pulse after each data byte written to a register.
- `rd_done_o` out 1: 1-cycle pulse when the initiator NACKs a read byte (end of read).

## Operation

- **Synchronizers:** `scl_i`/`sda_i` pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronized signals.
- **START:** SDA falls while SCL is high, from any state (including mid-byte, which is a repeated START). Clears the bit counter and goes to ADDR.
- **STOP:** SDA rises while SCL is high. Releases SDA, goes to IDLE, clears `busy_o`.
- **Bit handling:** data bits are sampled on SCL rising edges, MSB first. `sda_oe_o` changes only after an SCL falling edge.
- **State machine:**
  - IDLE to ADDR on START.
  - ADDR: after 8 bits, compare [7:1] with `DEV_ADDR`.
    - Match: go to ADDR_ACK.
    - Mismatch: release SDA and go to IDLE (NACK).
  - ADDR_ACK: drive 0 for one SCL period. Then go to PTR if R/W=0, or RDATA if R/W=1.
  - PTR: receive an 8-bit pointer, then PTR_ACK (always ACK), then WDATA.
  - WDATA: receive a byte, then WDATA_ACK (always ACK).
    - Write to the register at the pointer, pulse `wr_strobe_o`, increment the pointer.
    - Return to WDATA.
  - RDATA: load the byte at the pointer, shift it out on 8 SCL falling edges, then go to RDATA_ACK (SDA released).
    - Initiator ACK (SDA=0 sampled): increment the pointer and return to RDATA.
    - Initiator NACK: pulse `rd_done_o`, then wait with SDA released for STOP or START.
- **Register map** (pointer is 8-bit, wraps 0xFF→0x00):
  - 0x00: temp MSB (RO).
  - 0x01: temp LSB (RO).
  - 0x03: config (RW, reset 0x00).
  - 0x0B: `ID_VALUE` (RO).
  - All other addresses read 0x00. Writes to RO or unmapped registers are ACKed and discarded, and `wr_strobe_o` still pulses.
- **Pointer persistence:** the pointer survives STOP. A read without a pointer write uses the last pointer.
- **Temperature coherence:** the shadow loads from `temp_i` on `temp_upd_i` only when `busy_o`=0. A strobe that arrives while busy is held pending and applied in the cycle after STOP. Multiple pending strobes keep only the latest `temp_i`.

## Timing

- Reset values: `sda_oe_o`=0, `busy_o`=0, `wr_strobe_o`=0, `rd_done_o`=0, `cfg_o`=0x00. Pointer and shadow are 0x0000. State is IDLE.
- Reset mid-transfer releases SDA asynchronously in the same instant.
- Edge detection latency is `SYNC_STAGES`+1 `clk_i` cycles after a pin change.
- `sda_oe_o` updates no more than `SYNC_STAGES`+2 cycles after the SCL falling edge. It is stable for the entire SCL-high time.
- `busy_o` rises in the cycle ADDR_ACK is entered.
- `wr_strobe_o` and `rd_done_o` assert one cycle after the 9th-bit SCL rising edge is detected.
- START/STOP detection takes priority over a simultaneous SCL edge.

## Test plan

- **Pointer write then read:** `temp_i`=0x1A80 with strobe while idle. Write [0x96, 0x00], then repeated START with read [0x97] for 2 bytes (ACK, NACK). Expect ACKs, read data 0x1A then 0x80, one `rd_done_o` pulse.
- **Config write and ID read:** write [0x96, 0x03, 0xA5]. Expect `cfg_o`=0xA5 and one `wr_strobe_o`. Then read the ID at pointer 0x0B: expect 0xCB.
- **Address mismatch:** address byte 0x90. Expect SDA released during the 9th bit (NACK), `busy_o` stays 0, no register changes.
- **Coherent snapshot:** start a 2-byte read of 0x00. Between bytes, set `temp_i`=0x1234 with a strobe. Expect the old MSB/LSB for the whole transfer. After STOP, a new read returns 0x12, 0x34.
- **Pointer wrap and unmapped reads:** set pointer 0xFF and read 2 bytes. Expect 0x00 then the temp MSB (pointer wrapped to 0x00).
- **Abort cases:** START inserted after 4 address bits: expect a clean restart that ACKs the following full address. Assert `rst_i` during RDATA: expect `sda_oe_o`=0 immediately and `cfg_o`=0x00.
